// File: rtl/iob_csr_sub_pkg.sv
// Shared constants and types for the IOb CSR subordinate.
package iob_csr_sub_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned NBYTES = DATA_W / 8;

  // Value returned for reads of word indices beyond the register bank.
  localparam logic [DATA_W-1:0] OOR_RDATA = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACC  = 2'd2
  } rdy_state_e;

endpackage

// File: rtl/iob_csr_sub_rpipe.sv
// Read-return pipeline: LAT stages of valid/data. A data stage only loads
// when a valid entry moves into it, so the last stage holds the most
// recently delivered word between rvalid pulses.
module iob_csr_sub_rpipe #(
  parameter int unsigned LAT = 1,
  parameter int unsigned W   = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_cke,
  input  logic         i_vld,
  input  logic [W-1:0] i_data,
  output logic         o_vld,
  output logic [W-1:0] o_data
);

  logic [LAT-1:0] r_vld;
  logic [W-1:0]   r_data [LAT];

  // Shift valid every enabled cycle; move data only alongside a valid entry.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld <= '0;
      for (int unsigned s = 0; s < LAT; s++) begin
        r_data[s] <= '0;
      end
    end else if (i_cke) begin
      r_vld[0] <= i_vld;
      if (i_vld) begin
        r_data[0] <= i_data;
      end
      for (int unsigned s = 1; s < LAT; s++) begin
        r_vld[s] <= r_vld[s-1];
        if (r_vld[s-1]) begin
          r_data[s] <= r_data[s-1];
        end
      end
    end
  end

  assign o_vld  = r_vld[LAT-1];
  assign o_data = r_data[LAT-1];

endmodule

// File: rtl/iob_csr_sub.sv
// IOb native subordinate with a bank of byte-strobed 32-bit registers,
// programmable ready wait states and programmable read latency.
module iob_csr_sub
  import iob_csr_sub_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned N_REGS   = 8,
  parameter int unsigned WAIT_CYC = 0,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic              cke_i,
  input  logic              iob_valid_i,
  input  logic [ADDR_W-1:0] iob_addr_i,
  input  logic [DATA_W-1:0] iob_wdata_i,
  input  logic [NBYTES-1:0] iob_wstrb_i,
  output logic              iob_ready_o,
  output logic              iob_rvalid_o,
  output logic [DATA_W-1:0] iob_rdata_o
);

  localparam int unsigned IDX_W    = ADDR_W - 2;
  localparam logic [3:0]  CNT_LOAD = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  rdy_state_e        r_state;
  rdy_state_e        w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic              w_rdy;
  logic              w_xfer;
  logic              w_is_wr;
  logic              w_in_range;
  logic              w_wr_en;
  logic              w_rd_en;
  logic [IDX_W-1:0]  w_idx;
  logic [DATA_W-1:0] w_rd_word;
  logic [DATA_W-1:0] r_regs [N_REGS];
  logic              w_unused;

  assign w_idx      = iob_addr_i[ADDR_W-1:2];
  assign w_unused   = ^iob_addr_i[1:0];
  assign w_in_range = ({{(32-IDX_W){1'b0}}, w_idx} < N_REGS);

  // Ready FSM state and wait counter; frozen while the clock enable is low.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else if (cke_i) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state and combinational ready. ACC is entered on the edge where the
  // decremented count reaches zero, so ready rises after exactly WAIT_CYC
  // valid-high cycles (a single wait cycle goes straight from IDLE to ACC).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_rdy       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (iob_valid_i) begin
          if (WAIT_CYC == 0) begin
            w_rdy = 1'b1;
          end else if (CNT_LOAD == 4'd0) begin
            w_state_nxt = ST_ACC;
          end else begin
            w_state_nxt = ST_WAIT;
            w_cnt_nxt   = CNT_LOAD;
          end
        end
      end
      ST_WAIT: begin
        if (!iob_valid_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
          if (r_cnt <= 4'd1) begin
            w_state_nxt = ST_ACC;
          end
        end
      end
      ST_ACC: begin
        w_rdy       = iob_valid_i;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign iob_ready_o = cke_i & w_rdy;
  assign w_xfer      = iob_valid_i & iob_ready_o;
  assign w_is_wr     = |iob_wstrb_i;
  assign w_wr_en     = w_xfer & w_is_wr & w_in_range;
  assign w_rd_en     = w_xfer & ~w_is_wr;
  assign w_rd_word   = w_in_range ? r_regs[w_idx] : OOR_RDATA;

  // Register bank with per-byte strobe merge.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      for (int unsigned i = 0; i < N_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      for (int unsigned b = 0; b < NBYTES; b++) begin
        if (iob_wstrb_i[b]) begin
          r_regs[w_idx][8*b +: 8] <= iob_wdata_i[8*b +: 8];
        end
      end
    end
  end

  iob_csr_sub_rpipe #(
    .LAT (READ_LAT),
    .W   (DATA_W)
  ) u_rpipe (
    .i_clk   (clk_i),
    .i_rst_n (arst_n_i),
    .i_cke   (cke_i),
    .i_vld   (w_rd_en),
    .i_data  (w_rd_word),
    .o_vld   (iob_rvalid_o),
    .o_data  (iob_rdata_o)
  );

endmodule

// File: tb/tb_iob_csr_sub.sv
// Directed bench for iob_csr_sub: three instances with different
// wait/latency/size configurations sharing one clock, reset and enable.
module tb_iob_csr_sub;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic        cke = 1'b1;
  logic        valid [3];
  logic [4:0]  addr  [3];
  logic [31:0] wdata [3];
  logic [3:0]  wstrb [3];
  logic        ready  [3];
  logic        rvalid [3];
  logic [31:0] rdata  [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // u_a: no wait, latency 1, 8 regs
  iob_csr_sub #(.DATA_W(32), .ADDR_W(5), .N_REGS(8), .WAIT_CYC(0), .READ_LAT(1)) u_a (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
    .iob_valid_i(valid[0]), .iob_addr_i(addr[0]), .iob_wdata_i(wdata[0]), .iob_wstrb_i(wstrb[0]),
    .iob_ready_o(ready[0]), .iob_rvalid_o(rvalid[0]), .iob_rdata_o(rdata[0]));

  // u_b: 3 wait cycles, latency 1, 8 regs
  iob_csr_sub #(.DATA_W(32), .ADDR_W(5), .N_REGS(8), .WAIT_CYC(3), .READ_LAT(1)) u_b (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
    .iob_valid_i(valid[1]), .iob_addr_i(addr[1]), .iob_wdata_i(wdata[1]), .iob_wstrb_i(wstrb[1]),
    .iob_ready_o(ready[1]), .iob_rvalid_o(rvalid[1]), .iob_rdata_o(rdata[1]));

  // u_c: no wait, latency 4, 7 regs
  iob_csr_sub #(.DATA_W(32), .ADDR_W(5), .N_REGS(7), .WAIT_CYC(0), .READ_LAT(4)) u_c (
    .clk_i(clk), .arst_n_i(arst_n), .cke_i(cke),
    .iob_valid_i(valid[2]), .iob_addr_i(addr[2]), .iob_wdata_i(wdata[2]), .iob_wstrb_i(wstrb[2]),
    .iob_ready_o(ready[2]), .iob_rvalid_o(rvalid[2]), .iob_rdata_o(rdata[2]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Issue one request; returns the number of cycles ready stayed low.
  // Entered and left at posedge+1.
  task automatic req(input int k, input logic [4:0] a, input logic [31:0] d,
                     input logic [3:0] s, output int waited);
    valid[k] = 1'b1;
    addr[k]  = a;
    wdata[k] = d;
    wstrb[k] = s;
    waited   = 0;
    #1;
    while (!ready[k] && waited < 40) begin
      @(posedge clk); #1;
      waited++;
    end
    @(posedge clk); #1;
    valid[k] = 1'b0;
    wstrb[k] = 4'h0;
  endtask

  task automatic wr(input int k, input logic [4:0] a, input logic [31:0] d,
                    input logic [3:0] s, input int wexp, input string tag);
    int w;
    req(k, a, d, s, w);
    chk({tag, "_wait"}, w, wexp);
  endtask

  task automatic rd(input int k, input logic [4:0] a, input int lat,
                    input logic [31:0] exp, input int wexp, input string tag);
    int w;
    int n;
    req(k, a, 32'h0, 4'h0, w);
    chk({tag, "_wait"}, w, wexp);
    n = 1;
    while (!rvalid[k] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_data"}, rdata[k], exp);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, 32'(rvalid[k]), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "tb_iob_csr_sub timeout");
  end

  initial begin
    int np;
    for (int i = 0; i < 3; i++) begin
      valid[i] = 1'b0; addr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ready",  32'(ready[i]),  32'h0);
      chk("rst_rvalid", 32'(rvalid[i]), 32'h0);
      chk("rst_rdata",  rdata[i],       32'h0);
    end
    @(negedge clk); arst_n = 1'b1;
    @(posedge clk); #1;

    // Basic write/read, zero wait, latency 1
    wr(0, 5'h04, 32'h12345678, 4'hF, 0, "a_wr4");
    rd(0, 5'h04, 1, 32'h12345678, 0, "a_rd4");

    // Byte strobe merge; low address bits ignored
    wr(0, 5'h08, 32'hAABBCCDD, 4'hF, 0, "a_wr8");
    wr(0, 5'h08, 32'h00EE0000, 4'b0100, 0, "a_strb");
    rd(0, 5'h08, 1, 32'hAAEECCDD, 0, "a_rd8");
    rd(0, 5'h0B, 1, 32'hAAEECCDD, 0, "a_rdB");

    // Write then read of same word at consecutive edges
    valid[0] = 1'b1; addr[0] = 5'h0C; wdata[0] = 32'hCAFEF00D; wstrb[0] = 4'hF;
    #1;
    chk("a_wrrd_ready", 32'(ready[0]), 32'h1);
    @(posedge clk); #1;
    wstrb[0] = 4'h0;
    @(posedge clk); #1;
    valid[0] = 1'b0;
    chk("a_wrrd_rvalid", 32'(rvalid[0]), 32'h1);
    chk("a_wrrd_data", rdata[0], 32'hCAFEF00D);
    @(posedge clk); #1;
    chk("a_wrrd_pulse", 32'(rvalid[0]), 32'h0);

    // Clock enable low: no ready, nothing accepted
    cke = 1'b0;
    valid[0] = 1'b1; addr[0] = 5'h04; wstrb[0] = 4'h0;
    #1;
    chk("cke_ready", 32'(ready[0]), 32'h0);
    @(posedge clk); #1;
    valid[0] = 1'b0;
    cke = 1'b1;
    @(posedge clk); #1;
    chk("cke_norv", 32'(rvalid[0]), 32'h0);

    // Three wait cycles before ready
    wr(1, 5'h04, 32'h55AA55AA, 4'hF, 3, "b_wr4");
    rd(1, 5'h04, 1, 32'h55AA55AA, 3, "b_rd4");

    // Abandoned write after two cycles has no effect
    valid[1] = 1'b1; addr[1] = 5'h0C; wdata[1] = 32'hDEADBEEF; wstrb[1] = 4'hF;
    #1;
    chk("b_ab_rdy0", 32'(ready[1]), 32'h0);
    @(posedge clk); #1;
    chk("b_ab_rdy1", 32'(ready[1]), 32'h0);
    valid[1] = 1'b0; wstrb[1] = 4'h0;
    @(posedge clk); #1;
    rd(1, 5'h0C, 1, 32'h0, 3, "b_abandon");

    // Latency 4, back-to-back reads
    wr(2, 5'h00, 32'h1, 4'hF, 0, "c_wr0");
    wr(2, 5'h04, 32'h2, 4'hF, 0, "c_wr1");
    wr(2, 5'h08, 32'h3, 4'hF, 0, "c_wr2");
    valid[2] = 1'b1; addr[2] = 5'h00; wstrb[2] = 4'h0;
    #1;
    chk("c_b2b_ready", 32'(ready[2]), 32'h1);
    for (int j = 1; j <= 7; j++) begin
      @(posedge clk); #1;
      if (j == 1) addr[2] = 5'h04;
      if (j == 2) addr[2] = 5'h08;
      if (j == 3) valid[2] = 1'b0;
      chk("c_b2b_rvalid", 32'(rvalid[2]), (j >= 4 && j <= 6) ? 32'h1 : 32'h0);
      if (j >= 4) chk("c_b2b_data", rdata[2], (j == 7) ? 32'h3 : 32'(j - 3));
    end

    // Out of range index 7 with 7 registers
    wr(2, 5'h1C, 32'hFFFFFFFF, 4'hF, 0, "c_oor_wr");
    rd(2, 5'h1C, 4, 32'h0, 0, "c_oor_rd");
    rd(2, 5'h18, 4, 32'h0, 0, "c_rd6");

    // Reset with one read delivered and three in flight
    valid[2] = 1'b1; addr[2] = 5'h00; wstrb[2] = 4'h0;
    for (int j = 1; j <= 4; j++) begin
      @(posedge clk); #1;
      if (j == 1) addr[2] = 5'h04;
      if (j == 2) addr[2] = 5'h08;
      if (j == 3) addr[2] = 5'h00;
      if (j == 4) valid[2] = 1'b0;
    end
    chk("rst_pre_rvalid", 32'(rvalid[2]), 32'h1);
    chk("rst_pre_data", rdata[2], 32'h1);
    #1 arst_n = 1'b0;
    #1;
    chk("rst_mid_rvalid", 32'(rvalid[2]), 32'h0);
    chk("rst_mid_rdata", rdata[2], 32'h0);
    @(posedge clk);
    @(negedge clk); arst_n = 1'b1;
    np = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rvalid[2]) np++;
    end
    chk("rst_no_pulses", np, 0);
    rd(2, 5'h00, 4, 32'h0, 0, "rst_c0");
    rd(2, 5'h04, 4, 32'h0, 0, "rst_c1");
    rd(2, 5'h08, 4, 32'h0, 0, "rst_c2");
    rd(0, 5'h04, 1, 32'h0, 0, "rst_a1");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
